// File: rtl/dec7seg_scan_pkg.sv
// Shared constants and types for the multiplexed seven-segment scanner.
package dec7seg_scan_pkg;

  // Segment bit order is {g, f, e, d, c, b, a}; 1 lights a segment.
  localparam logic [6:0] SEG_DARK    = 7'b0000000;
  localparam logic [3:0] DIGIT_RESET = 4'hF;

  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b1111100;
  localparam logic [6:0] SEG_C = 7'b0111001;
  localparam logic [6:0] SEG_D = 7'b1011110;
  localparam logic [6:0] SEG_E = 7'b1111001;
  localparam logic [6:0] SEG_F = 7'b1110001;

  typedef enum logic {
    PH_BLANK,
    PH_SHOW
  } phase_e;

endpackage

// File: rtl/dec7seg_scan_dec7seg.sv
// Seven-segment decoder: codes 0..5 render the glyphs A..F, every other code is dark.
module dec7seg
  import dec7seg_scan_pkg::*;
(
  input  logic [3:0] i_val,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DARK;
    case (i_val)
      4'h0:    o_seg = SEG_A;
      4'h1:    o_seg = SEG_B;
      4'h2:    o_seg = SEG_C;
      4'h3:    o_seg = SEG_D;
      4'h4:    o_seg = SEG_E;
      4'h5:    o_seg = SEG_F;
      default: o_seg = SEG_DARK;
    endcase
  end

endmodule

// File: rtl/dec7seg_scan.sv
// Time-multiplexed display scanner: one shared decoder, per-digit value registers,
// fixed-length slots with a dark gap at the start of each to avoid ghosting.
module dec7seg_scan
  import dec7seg_scan_pkg::*;
#(
  parameter int unsigned NDIG      = 4,
  parameter int unsigned DIV       = 1000,
  parameter int unsigned BLANK_CYC = 2,
  parameter int unsigned AW        = $clog2(NDIG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [3:0]      wr_data,
  input  logic [NDIG-1:0] blank_mask,
  output logic [NDIG-1:0] dig_sel,
  output logic [6:0]      seg,
  output logic [AW-1:0]   cur_digit,
  output logic            frame_tick
);

  localparam int unsigned   CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CntLast  = CW'(DIV - 1);
  localparam logic [AW-1:0] SlotLast = AW'(NDIG - 1);

  logic [CW-1:0]   r_cnt;
  logic [AW-1:0]   r_slot;
  logic            r_wrapped;
  logic [3:0]      r_digit [NDIG];

  logic [NDIG-1:0] r_dig_sel;
  logic [6:0]      r_seg;
  logic [AW-1:0]   r_cur_digit;
  logic            r_frame_tick;

  logic            w_cnt_last;
  logic            w_slot_last;
  logic            w_wr_hit;
  logic            w_show;
  phase_e          w_phase;
  logic [3:0]      w_cur_val;
  logic [6:0]      w_dec_seg;

  assign w_cnt_last  = (r_cnt == CntLast);
  assign w_slot_last = (r_slot == SlotLast);
  assign w_phase     = (32'(r_cnt) < BLANK_CYC) ? PH_BLANK : PH_SHOW;
  assign w_show      = (w_phase == PH_SHOW) && !blank_mask[r_slot];
  assign w_cur_val   = r_digit[r_slot];
  // Addresses past the last digit only exist when NDIG is not a power of two.
  assign w_wr_hit    = wr_en && (32'(wr_addr) < NDIG);

  dec7seg u_dec (
    .i_val (w_cur_val),
    .o_seg (w_dec_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NDIG; i++) begin
        r_digit[i] <= DIGIT_RESET;
      end
    end else if (w_wr_hit) begin
      r_digit[wr_addr] <= wr_data;
    end
  end

  // Slot sequencing plus the output stage; outputs describe the state before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_slot       <= '0;
      r_wrapped    <= 1'b0;
      r_dig_sel    <= '0;
      r_seg        <= SEG_DARK;
      r_cur_digit  <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_dig_sel    <= w_show ? (NDIG'(1) << r_slot) : '0;
      r_seg        <= w_show ? w_dec_seg : SEG_DARK;
      r_cur_digit  <= r_slot;
      // r_wrapped keeps the very first scan after reset from raising a tick.
      r_frame_tick <= r_wrapped && (r_cnt == '0) && (r_slot == '0);

      if (w_cnt_last) begin
        r_cnt <= '0;
        if (w_slot_last) begin
          r_slot    <= '0;
          r_wrapped <= 1'b1;
        end else begin
          r_slot <= r_slot + 1'b1;
        end
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign dig_sel    = r_dig_sel;
  assign seg        = r_seg;
  assign cur_digit  = r_cur_digit;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_dec7seg_scan.sv
// Bench for dec7seg_scan: an NDIG=4 and an NDIG=3 instance share the write port;
// a cycle-count model checks both every cycle, directed literals pin the model.
module tb_dec7seg_scan;

  localparam int DIV   = 8;
  localparam int BLANK = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic [3:0] blank_mask;
  logic [2:0] blank_mask_b;

  logic [3:0] a_dig_sel;
  logic [6:0] a_seg;
  logic [1:0] a_cur;
  logic       a_tick;
  logic [2:0] b_dig_sel;
  logic [6:0] b_seg;
  logic [1:0] b_cur;
  logic       b_tick;

  int n_checks = 0;
  int n_fail   = 0;
  int k        = 0;

  always #5 clk = ~clk;

  dec7seg_scan #(.NDIG(4), .DIV(DIV), .BLANK_CYC(BLANK)) u_dut_a (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .blank_mask (blank_mask),
    .dig_sel    (a_dig_sel),
    .seg        (a_seg),
    .cur_digit  (a_cur),
    .frame_tick (a_tick)
  );

  dec7seg_scan #(.NDIG(3), .DIV(DIV), .BLANK_CYC(BLANK)) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .blank_mask (blank_mask_b),
    .dig_sel    (b_dig_sel),
    .seg        (b_seg),
    .cur_digit  (b_cur),
    .frame_tick (b_tick)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at k=%0d: got %0h, expected %0h", name, k, act, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0:    return 7'b1110111;
      4'h1:    return 7'b1111100;
      4'h2:    return 7'b0111001;
      4'h3:    return 7'b1011110;
      4'h4:    return 7'b1111001;
      4'h5:    return 7'b1110001;
      default: return 7'b0000000;
    endcase
  endfunction

  // Model: cycles elapsed since reset determine slot and phase directly.
  int         m_p     [2];
  logic [3:0] m_dig   [2][4];
  bit         m_valid [2];
  int         m_ndig  [2] = '{4, 3};

  always @(posedge clk) begin
    logic [3:0] e_sel  [2];
    logic [6:0] e_seg  [2];
    int         e_cur  [2];
    bit         e_tick [2];
    bit         en     [2];
    logic [3:0] msk    [2];
    int         cnt;
    int         slot;
    msk[0] = blank_mask;
    msk[1] = {1'b0, blank_mask_b};
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        e_sel[i]  = '0;
        e_seg[i]  = '0;
        e_cur[i]  = 0;
        e_tick[i] = 1'b0;
        m_p[i]    = 0;
        for (int j = 0; j < 4; j++) m_dig[i][j] = 4'hF;
        m_valid[i] = 1'b1;
      end else begin
        cnt  = m_p[i] % DIV;
        slot = (m_p[i] / DIV) % m_ndig[i];
        if (cnt >= BLANK && !msk[i][slot]) begin
          e_sel[i] = 4'(1 << slot);
          e_seg[i] = glyph(m_dig[i][slot]);
        end else begin
          e_sel[i] = '0;
          e_seg[i] = '0;
        end
        e_cur[i]  = slot;
        e_tick[i] = (cnt == 0) && (slot == 0) && (m_p[i] >= DIV * m_ndig[i]);
        m_p[i]++;
        if (wr_en && int'(wr_addr) < m_ndig[i]) m_dig[i][wr_addr] = wr_data;
      end
      en[i] = m_valid[i];
    end
    #1;
    if (en[0]) begin
      chk("model_a_dig_sel", a_dig_sel, e_sel[0]);
      chk("model_a_seg", a_seg, e_seg[0]);
      chk("model_a_cur", a_cur, e_cur[0]);
      chk("model_a_tick", a_tick, e_tick[0]);
    end
    if (en[1]) begin
      chk("model_b_dig_sel", b_dig_sel, e_sel[1]);
      chk("model_b_seg", b_seg, e_seg[1]);
      chk("model_b_cur", b_cur, e_cur[1]);
      chk("model_b_tick", b_tick, e_tick[1]);
    end
  end

  task automatic adv_to(input int t);
    while (k < t) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    rst          = 1'b1;
    wr_en        = 1'b0;
    wr_addr      = '0;
    wr_data      = '0;
    blank_mask   = '0;
    blank_mask_b = '0;

    // Reset held five cycles, outputs dark throughout.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_dig_sel", a_dig_sel, 4'b0000);
      chk("rst_seg", a_seg, 7'b0000000);
      chk("rst_tick", a_tick, 1'b0);
    end
    rst = 1'b0;
    k   = 0;

    // Free run with reset digit values (all dark glyphs).
    adv_to(2);  chk("c2_blank", a_dig_sel, 4'b0000);
    adv_to(3);  chk("c3_sel", a_dig_sel, 4'b0001); chk("c3_seg", a_seg, 7'b0000000);
    adv_to(8);  chk("c8_sel", a_dig_sel, 4'b0001);
    adv_to(9);  chk("c9_gap", a_dig_sel, 4'b0000);
    adv_to(10); chk("c10_gap", a_dig_sel, 4'b0000);
    adv_to(32); chk("c32_no_tick", a_tick, 1'b0);
    adv_to(33); chk("c33_tick", a_tick, 1'b1); chk("c33_cur", a_cur, 2'd0);
    adv_to(34); chk("c34_tick_off", a_tick, 1'b0);
    adv_to(65); chk("c65_tick", a_tick, 1'b1);

    // Reset, then load digits 0..3 while the scan restarts.
    rst = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    k       = 0;
    wr_en   = 1'b1;
    wr_addr = 2'd0; wr_data = 4'd0;
    adv_to(1); wr_addr = 2'd1; wr_data = 4'd1;
    adv_to(2); wr_addr = 2'd2; wr_data = 4'd2;
    adv_to(3);
    chk("w_s0_sel", a_dig_sel, 4'b0001); chk("w_s0_seg", a_seg, 7'b1110111);
    chk("b_s0_seg", b_seg, 7'b1110111);
    wr_addr = 2'd3; wr_data = 4'd3;
    adv_to(4);  wr_en = 1'b0;
    adv_to(11); chk("w_s1_sel", a_dig_sel, 4'b0010); chk("w_s1_seg", a_seg, 7'b1111100);
    adv_to(19); chk("w_s2_sel", a_dig_sel, 4'b0100); chk("w_s2_seg", a_seg, 7'b0111001);
    chk("b_s2_sel", b_dig_sel, 3'b100); chk("b_s2_seg", b_seg, 7'b0111001);
    adv_to(27); chk("w_s3_sel", a_dig_sel, 4'b1000); chk("w_s3_seg", a_seg, 7'b1011110);
    // NDIG=3 ignored the addr-3 write and is already back on slot 0.
    chk("b_wrap_sel", b_dig_sel, 3'b001); chk("b_wrap_seg", b_seg, 7'b1110111);

    // Mask slot 2.
    blank_mask = 4'b0100;
    adv_to(43); chk("m_s1_seg", a_seg, 7'b1111100);
    adv_to(51); chk("m_s2_sel", a_dig_sel, 4'b0000); chk("m_s2_seg", a_seg, 7'b0000000);
    chk("m_s2_cur", a_cur, 2'd2);
    adv_to(59); chk("m_s3_sel", a_dig_sel, 4'b1000); chk("m_s3_seg", a_seg, 7'b1011110);
    blank_mask = 4'b0000;

    // Write latency into the slot being shown.
    adv_to(75); wr_en = 1'b1; wr_addr = 2'd1; wr_data = 4'd5;
    adv_to(76); wr_en = 1'b0; chk("lat_old_seg", a_seg, 7'b1111100);
    adv_to(77); chk("lat_new_seg", a_seg, 7'b1110001); chk("lat_sel", a_dig_sel, 4'b0010);
    wr_en = 1'b1; wr_data = 4'd9;
    adv_to(78); wr_en = 1'b0; chk("lat9_old_seg", a_seg, 7'b1110001);
    adv_to(79); chk("lat9_dark", a_seg, 7'b0000000); chk("lat9_sel", a_dig_sel, 4'b0010);

    // One-cycle reset during slot 2 SHOW.
    adv_to(84); chk("pre_rst_seg", a_seg, 7'b0111001);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_sel", a_dig_sel, 4'b0000); chk("mid_rst_seg", a_seg, 7'b0000000);
    chk("mid_rst_cur", a_cur, 2'd0);
    rst     = 1'b0;
    k       = 0;
    wr_en   = 1'b1; wr_addr = 2'd3; wr_data = 4'd5;
    adv_to(1);  wr_en = 1'b0;
    adv_to(3);  chk("dk_s0_sel", a_dig_sel, 4'b0001); chk("dk_s0_seg", a_seg, 7'b0000000);
    adv_to(11); chk("dk_s1_seg", a_seg, 7'b0000000);
    adv_to(19); chk("dk_b_s2_sel", b_dig_sel, 3'b100); chk("dk_b_s2_seg", b_seg, 7'b0000000);
    adv_to(27); chk("dk_s3_seg", a_seg, 7'b1110001); chk("dk_b_s0_seg", b_seg, 7'b0000000);
    adv_to(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
